uart_tx: RTL and testbench



---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_baud_cnt.sv | 28 ++
 rtl/uart_tx.sv | 117 +++++++++++
 tb/tb_uart_tx.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART frame constants, state encoding and baud-divider helper
package uart_pkg;

  localparam int DATA_W         = 8;
  localparam int IDX_W          = $clog2(DATA_W);
  localparam int FRAME_BITS     = 10;
  localparam int FRAME_BITS_PAR = 11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_t;

  // Clocks per bit; RX and TX must both derive it here so their bit windows agree.
  function automatic int calc_b_cnt(input int clk_f, input int baud);
    return clk_f / baud;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// rtl/uart_baud_cnt.sv - bit-period counter 0..B_CNT-1 with clear and end-of-bit tick
module uart_baud_cnt #(
  parameter int B_CNT = 4,
  parameter int CW    = (B_CNT > 1) ? $clog2(B_CNT) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam logic [CW-1:0] LAST = CW'(B_CNT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter, start + 8 data LSB-first + stop; UART_TX_PARITY_EN adds a parity bit
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_F      = 50000000,
  parameter int UART_B     = 115200,
  parameter int B_CNT      = calc_b_cnt(CLK_F, UART_B),
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       TX_EN,
  input  logic       TX_START,
  input  logic [7:0] TX_DATA,
  output logic       TX_OUT,
  output logic       BUSY,
  output logic       DONE
);

  uart_state_t       state;
  logic [DATA_W-1:0] shift;
  logic [IDX_W-1:0]  idx;
  logic              bit_tick;
  logic              baud_clr;

`ifdef UART_TX_PARITY_EN
  logic par_bit;
`else
  logic unused_parity_odd;
  assign unused_parity_odd = PARITY_ODD;
`endif

  // Holding the counter at zero while idle makes the start bit exactly B_CNT cycles.
  assign baud_clr = (state == ST_IDLE) || !TX_EN;

  uart_baud_cnt #(.B_CNT(B_CNT)) u_baud (
    .clk  (CLK),
    .rst  (RST),
    .clr  (baud_clr),
    .tick (bit_tick)
  );

  always_ff @(posedge CLK) begin
    if (RST || !TX_EN) begin
      state  <= ST_IDLE;
      shift  <= '0;
      idx    <= '0;
      TX_OUT <= 1'b1;
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_bit <= 1'b0;
`endif
    end else begin
      DONE <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (TX_START) begin
            state  <= ST_START;
            shift  <= TX_DATA;
            idx    <= '0;
            TX_OUT <= 1'b0;
            BUSY   <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_bit <= (^TX_DATA) ^ PARITY_ODD;
`endif
          end
        end
        ST_START: begin
          if (bit_tick) begin
            state  <= ST_DATA;
            TX_OUT <= shift[0];
          end
        end
        ST_DATA: begin
          if (bit_tick) begin
            if (idx == IDX_W'(DATA_W - 1)) begin
`ifdef UART_TX_PARITY_EN
              state  <= ST_PARITY;
              TX_OUT <= par_bit;
`else
              state  <= ST_STOP;
              TX_OUT <= 1'b1;
`endif
            end else begin
              // Next bit is presented straight from shift[1] so TX_OUT stays a pure register.
              shift  <= shift >> 1;
              idx    <= idx + IDX_W'(1);
              TX_OUT <= shift[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (bit_tick) begin
            state  <= ST_STOP;
            TX_OUT <= 1'b1;
          end
        end
`endif
        ST_STOP: begin
          if (bit_tick) begin
            state <= ST_IDLE;
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
          end
        end
        default: begin
          state  <= ST_IDLE;
          TX_OUT <= 1'b1;
          BUSY   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - randomized self-checking bench for uart_tx against a frame-level line model
module tb_uart_tx;

  localparam int CLK_F  = 8;
  localparam int UART_B = 2;
  localparam int B      = CLK_F / UART_B;
  localparam bit PODD   = 1'b0;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int L  = NB * B;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_en;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_out;
  logic       busy;
  logic       done;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx #(.CLK_F(CLK_F), .UART_B(UART_B), .PARITY_ODD(PODD)) dut (
    .CLK      (clk),
    .RST      (rst),
    .TX_EN    (tx_en),
    .TX_START (tx_start),
    .TX_DATA  (tx_data),
    .TX_OUT   (tx_out),
    .BUSY     (busy),
    .DONE     (done)
  );

  // Inputs are always changed at a falling edge; callers are sitting at one.
  task automatic start_frame(input logic [7:0] d);
    tx_data  = d;
    tx_start = 1'b1;
  endtask

  task automatic idle_check(input int n, input string name);
    logic [2:0] got;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      got = {tx_out, busy, done};
      total++;
      if (got !== 3'b100) begin
        bad++;
        $display("FAIL %s cycle %0d {tx,busy,done} got=%b want=100", name, i, got);
      end
    end
  endtask

  // Line model: the frame is a list of bits each held B cycles after the accept edge,
  // followed by one idle cycle carrying DONE.
  task automatic run_frame(input logic [7:0] d, input int poke_c, input logic [7:0] poke_d,
                           input int abort_c, input bit abort_rst,
                           output int done_rel, output int done_abs, output logic [7:0] rx);
    bit         fr[$];
    bit         line[NB];
    logic [2:0] exp;
    logic [2:0] got;
    bit         stop;
    stop = 1'b0;
    fr.push_back(1'b0);
    for (int k = 0; k < 8; k++) fr.push_back(d[k]);
`ifdef UART_TX_PARITY_EN
    fr.push_back(bit'($countones(d) % 2) ^ PODD);
`endif
    fr.push_back(1'b1);
    done_rel = -1;
    done_abs = -1;
    rx       = '0;
    for (int c = 1; c <= L + 1 && !stop; c++) begin
      @(negedge clk);
      exp = (c <= L) ? {fr[(c - 1) / B], 1'b1, 1'b0} : 3'b101;
      got = {tx_out, busy, done};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL frame d=%02h c=%0d {tx,busy,done} got=%b want=%b", d, c, got, exp);
      end
      if (done === 1'b1 && done_rel < 0) begin
        done_rel = c;
        done_abs = cyc;
      end
      if (c <= L && (c - 1) % B == B / 2) line[(c - 1) / B] = tx_out;
      if (c == 1) tx_start = 1'b0;
      if (c == poke_c) begin
        tx_start = 1'b1;
        tx_data  = poke_d;
      end else if (c == poke_c + 1) begin
        tx_start = 1'b0;
      end
      if (c == abort_c) begin
        tx_start = 1'b0;
        if (abort_rst) rst = 1'b1;
        else tx_en = 1'b0;
        stop = 1'b1;
      end
    end
    if (stop) begin
      @(negedge clk);
      got = {tx_out, busy, done};
      total++;
      if (got !== 3'b100) begin
        bad++;
        $display("FAIL abort d=%02h at c=%0d rst=%0d {tx,busy,done} got=%b want=100",
                 d, abort_c, abort_rst, got);
      end
      rst   = 1'b0;
      tx_en = 1'b1;
      idle_check(2, "after_abort");
    end else begin
      for (int k = 0; k < 8; k++) rx[k] = line[k + 1];
    end
  endtask

  task automatic test_reset();
    logic [2:0] got;
    int dr, da;
    logic [7:0] rx;
    tx_en    = 1'b1;
    tx_data  = 8'hFF;
    tx_start = 1'b1;
    rst      = 1'b1;
    repeat (3) begin
      @(negedge clk);
      got = {tx_out, busy, done};
      total++;
      if (got !== 3'b100) begin
        bad++;
        $display("FAIL reset {tx,busy,done} got=%b want=100", got);
      end
    end
    tx_start = 1'b0;
    rst      = 1'b0;
    idle_check(2, "post_reset");
    start_frame(8'h5A);
    run_frame(8'h5A, -10, 8'h00, 7, 1'b1, dr, da, rx);
  endtask

  task automatic test_single();
    int dr, da;
    logic [7:0] rx;
    start_frame(8'hA5);
    run_frame(8'hA5, -10, 8'h00, -1, 1'b0, dr, da, rx);
    total++;
    if (dr != L + 1) begin
      bad++;
      $display("FAIL single_done_cycle got=%0d want=%0d", dr, L + 1);
    end
    total++;
    if (rx !== 8'hA5) begin
      bad++;
      $display("FAIL single_loopback got=%02h want=a5", rx);
    end
    idle_check(1, "single_tail");
  endtask

  task automatic test_busy_ignore();
    int dr, da;
    logic [7:0] rx;
    start_frame(8'h3C);
    run_frame(8'h3C, 10, 8'hFF, -1, 1'b0, dr, da, rx);
    total++;
    if (rx !== 8'h3C) begin
      bad++;
      $display("FAIL busy_ignore_data got=%02h want=3c", rx);
    end
    idle_check(L / 2, "busy_ignore_not_queued");
  endtask

  task automatic test_back_to_back();
    int dr1, da1, dr2, da2;
    logic [7:0] rx1, rx2;
    start_frame(8'h00);
    run_frame(8'h00, -10, 8'h00, -1, 1'b0, dr1, da1, rx1);
    start_frame(8'hFF);
    run_frame(8'hFF, -10, 8'h00, -1, 1'b0, dr2, da2, rx2);
    total++;
    if (da2 - da1 != L + 1) begin
      bad++;
      $display("FAIL b2b_done_spacing got=%0d want=%0d", da2 - da1, L + 1);
    end
    total++;
    if ({rx1, rx2} !== 16'h00FF) begin
      bad++;
      $display("FAIL b2b_data got=%02h,%02h want=00,ff", rx1, rx2);
    end
    idle_check(2, "b2b_tail");
  endtask

  task automatic test_abort();
    int dr, da;
    logic [7:0] rx;
    tx_en    = 1'b0;
    tx_data  = 8'h81;
    tx_start = 1'b1;
    idle_check(2, "disabled_no_accept");
    tx_start = 1'b0;
    tx_en    = 1'b1;
    idle_check(1, "reenable_idle");
    start_frame(8'hAA);
    run_frame(8'hAA, -10, 8'h00, 15, 1'b0, dr, da, rx);
    start_frame(8'h55);
    run_frame(8'h55, -10, 8'h00, -1, 1'b0, dr, da, rx);
    total++;
    if (rx !== 8'h55 || dr != L + 1) begin
      bad++;
      $display("FAIL abort_recover got=%02h done@%0d want=55 done@%0d", rx, dr, L + 1);
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    int dr, da;
    logic [7:0] rx;
    start_frame(8'h07);
    run_frame(8'h07, -10, 8'h00, -1, 1'b0, dr, da, rx);
    total++;
    if (dr != 45) begin
      bad++;
      $display("FAIL parity_done_cycle got=%0d want=45", dr);
    end
  endtask
`endif

  task automatic test_random();
    int dr, da, pc, ac, gap, mode;
    bit ar;
    logic [7:0] d, rx;
    for (int i = 0; i < 24; i++) begin
      d    = 8'($urandom);
      mode = int'($urandom_range(0, 9));
      gap  = int'($urandom_range(0, 3));
      pc   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, L)) : -10;
      ac   = -1;
      ar   = 1'b0;
      if (mode < 2) begin
        ac = int'($urandom_range(1, L));
        ar = (mode == 1);
      end
      if (gap > 0) idle_check(gap, "rand_gap");
      start_frame(d);
      run_frame(d, pc, 8'($urandom), ac, ar, dr, da, rx);
      if (ac < 0) begin
        total++;
        if (rx !== d || dr != L + 1) begin
          bad++;
          $display("FAIL rand_frame %0d got=%02h done@%0d want=%02h done@%0d", i, rx, dr, d, L + 1);
        end
      end
    end
    idle_check(2, "rand_tail");
  endtask

  initial begin
    rst      = 1'b1;
    tx_en    = 1'b0;
    tx_start = 1'b0;
    tx_data  = 8'h00;
    repeat (2) @(negedge clk);
    rst   = 1'b0;
    tx_en = 1'b1;
    idle_check(2, "idle_after_init");
    test_reset();
    test_single();
    test_busy_ignore();
    test_back_to_back();
    test_abort();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
